// File: rtl/alu_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl_if
// Description : Command and result handshake bundle for the ALU sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_ctrl_if #(
    parameter int WIDTH = 3
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [1:0]           in_sel;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_result;
    logic                 out_dz;
    logic                 busy;

    modport master (
        output in_valid, in_a, in_b, in_sel, out_ready,
        input  in_ready, out_valid, out_result, out_dz, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sel, out_ready,
        output in_ready, out_valid, out_result, out_dz, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl
// Description : Sequencer for add/sub/mul/div over one shared adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl #(
    parameter int WIDTH = 3
) (
    input  wire logic       clk,
    input  wire logic       rst,
    alu_seq_ctrl_if.slave   bus
);
    localparam int c_RW = 2 * WIDTH;
    localparam int c_CW = $clog2(WIDTH + 1);

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_MUL = 2'b10;
    localparam logic [1:0] c_OP_DIV = 2'b11;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nx;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_busy;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [1:0]        r_sel;
    logic              r_dz_op;
    logic [c_RW-1:0]   r_acc;
    logic [c_RW-1:0]   r_x;
    logic [WIDTH-1:0]  r_y;
    logic [c_CW-1:0]   r_cnt;
    logic [c_RW-1:0]   r_result;
    logic              r_dz;

    logic [WIDTH:0]    w_rem_sh;
    logic [c_RW-1:0]   w_op_x;
    logic [c_RW-1:0]   w_op_y;
    logic              w_sub;
    logic [c_RW:0]     w_sum;
    logic              w_geq;
    logic [c_RW-1:0]   w_acc_nx;
    logic [WIDTH-1:0]  w_y_nx;
    logic [c_RW-1:0]   w_res;
    logic              w_accept;
    logic              w_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_nx = c_ST_EXEC;
            end
            c_ST_EXEC: begin
                w_busy = 1'b1;
                if (r_cnt == c_CW'(1)) w_state_nx = c_ST_DONE;
            end
            c_ST_DONE: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                if (bus.out_ready) w_state_nx = c_ST_IDLE;
            end
            default: w_state_nx = c_ST_IDLE;
        endcase
    end

    assign w_accept = (r_state == c_ST_IDLE) && bus.in_valid;
    assign w_last   = (r_state == c_ST_EXEC) && (r_cnt == c_CW'(1));

    // Operand steering: every operation funnels through the one adder/subtractor.
    always_comb begin
        w_rem_sh = {r_acc[WIDTH-1:0], r_y[WIDTH-1]};
        w_op_x   = {{(c_RW-WIDTH){1'b0}}, r_a};
        w_op_y   = {{(c_RW-WIDTH){1'b0}}, r_b};
        w_sub    = 1'b0;
        case (r_sel)
            c_OP_SUB: w_sub = 1'b1;
            c_OP_MUL: begin
                w_op_x = r_acc;
                w_op_y = r_x;
            end
            c_OP_DIV: begin
                w_op_x = c_RW'(w_rem_sh);
                w_sub  = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_sum = {1'b0, w_op_x} + {1'b0, w_op_y ^ {c_RW{w_sub}}} + {{c_RW{1'b0}}, w_sub};
    // Carry out of x + ~y + 1 means the trial subtraction did not borrow.
    assign w_geq = w_sum[c_RW];

    always_comb begin
        w_acc_nx = w_sum[c_RW-1:0];
        w_y_nx   = r_y;
        w_res    = w_sum[c_RW-1:0];
        case (r_sel)
            c_OP_MUL: begin
                w_acc_nx = r_y[0] ? w_sum[c_RW-1:0] : r_acc;
                w_y_nx   = r_y >> 1;
                w_res    = w_acc_nx;
            end
            c_OP_DIV: begin
                w_acc_nx = w_geq ? w_sum[c_RW-1:0] : c_RW'(w_rem_sh);
                w_y_nx   = {r_y[WIDTH-2:0], w_geq};
                w_res    = r_dz_op ? {r_a, {WIDTH{1'b1}}} : {w_acc_nx[WIDTH-1:0], w_y_nx};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sel    <= '0;
            r_dz_op  <= 1'b0;
            r_acc    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_dz     <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.in_a;
            r_b     <= bus.in_b;
            r_sel   <= bus.in_sel;
            r_dz_op <= (bus.in_sel == c_OP_DIV) && (bus.in_b == '0);
            r_acc   <= '0;
            r_x     <= {{(c_RW-WIDTH){1'b0}}, bus.in_a};
            r_y     <= (bus.in_sel == c_OP_DIV) ? bus.in_a : bus.in_b;
            if ((bus.in_sel == c_OP_MUL) || ((bus.in_sel == c_OP_DIV) && (bus.in_b != '0))) begin
                r_cnt <= c_CW'(WIDTH);
            end else begin
                r_cnt <= c_CW'(1);
            end
        end else if (r_state == c_ST_EXEC) begin
            r_cnt <= r_cnt - c_CW'(1);
            r_acc <= w_acc_nx;
            r_x   <= r_x << 1;
            r_y   <= w_y_nx;
            if (w_last) begin
                r_result <= w_res;
                r_dz     <= r_dz_op;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.busy       = w_busy;
    assign bus.out_result = r_result;
    assign bus.out_dz     = r_dz;
endmodule
`default_nettype wire
